// File: rtl/shift_pkg.sv
// Shared definitions for the shift serial link: the default word width, the receiver/transmitter
// state type, and frame-length and bit-counter sizing helpers.
package shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits on the wire per word: the data bits, plus one trailing even-parity bit when enabled.
  function automatic int unsigned FRAME_LEN(input int unsigned width, input bit parity);
    if (parity) begin
      return width + 1;
    end
    return width;
  endfunction

  // Counter that must hold 0..frame, so it is sized for frame+1 values.
  function automatic int unsigned CNT_WIDTH(input int unsigned frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/shift_deser.sv
// Serial-in, parallel-out receiver for the shift link: LSB-first words, valid/ready holding
// register, sticky overrun. Define SHIFT_DESER_PARITY_EN to expect a trailing even-parity bit.
module shift_deser
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cntrl,
  input  logic             sin,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam int unsigned Frame = FRAME_LEN(WIDTH, ParityEn);
  localparam int unsigned CntW  = CNT_WIDTH(Frame);
  localparam logic [CntW-1:0] LastCnt = CntW'(Frame - 1);

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_sr;
  logic [WIDTH-1:0]  r_word;
  logic              r_valid;
  logic              r_done;
  logic              r_overrun;
  logic              w_last;
  logic              w_shift_en;

`ifdef SHIFT_DESER_PARITY_EN
  localparam logic [CntW-1:0] DataCnt = CntW'(WIDTH);
  logic r_par;
  logic r_perr_pend;
  logic r_perr;
  // The parity bit is the last of the frame and never enters the shift register.
  assign w_shift_en = (r_cnt < DataCnt);
`else
  assign w_shift_en = 1'b1;
`endif

  assign w_last = (r_cnt == LastCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      r_par       <= 1'b0;
      r_perr_pend <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      // r_done marks that r_sr holds a word completed on the previous edge.
      if (r_done) begin
        if (r_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_word  <= r_sr;
          r_valid <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
          r_perr  <= r_perr_pend;
`endif
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      r_done <= 1'b0;

      if (!cntrl) begin
        r_state <= IDLE;
        r_cnt   <= '0;
`ifdef SHIFT_DESER_PARITY_EN
        r_par   <= 1'b0;
`endif
      end else begin
        if (w_shift_en) begin
          r_sr <= {sin, r_sr[WIDTH-1:1]};
        end
        if (w_last) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_done  <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
          r_perr_pend <= r_par ^ sin;
          r_par       <= 1'b0;
`endif
        end else begin
          r_state <= SHIFT;
          r_cnt   <= r_cnt + CntW'(1);
`ifdef SHIFT_DESER_PARITY_EN
          r_par   <= r_par ^ sin;
`endif
        end
      end
    end
  end

  assign out_word  = r_word;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;
  // SHIFT is exactly the counter-nonzero condition.
  assign busy      = (r_state == SHIFT);

`ifdef SHIFT_DESER_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser (WIDTH=4): vector table, directed corner sequences, and a random run
// checked against a queue-based frame model. Follows SHIFT_DESER_PARITY_EN like the RTL.
module tb_shift_deser;

`ifdef SHIFT_DESER_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = 5;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cntrl = 1'b0;
  logic       sin = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] out_word;
  logic       out_valid;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_pass   = 0;

  shift_deser #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cntrl      (cntrl),
    .sin        (sin),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic rd);
    rst = r; cntrl = c; sin = s; out_ready = rd;
    tick();
  endtask

  // Reference model: collect frame bits in a queue; word is bits[i] weighted by 2**i.
  logic       q[$];
  logic [3:0] m_word, m_pend_word;
  logic       m_valid, m_ovr, m_perr, m_pend, m_pend_perr;

  task automatic model_step();
    logic [3:0] w;
    logic p;
    if (rst) begin
      q.delete();
      m_word = '0; m_valid = 0; m_ovr = 0; m_perr = 0; m_pend = 0; m_pend_perr = 0;
      m_pend_word = '0;
    end else begin
      if (m_pend) begin
        if (m_valid && !out_ready) m_ovr = 1;
        else begin
          m_word = m_pend_word; m_valid = 1; m_perr = m_pend_perr;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      m_pend = 0;
      if (cntrl) begin
        q.push_back(sin);
        if (q.size() == FRAME) begin
          w = '0; p = 0;
          for (int i = 0; i < FRAME; i++) begin
            if (i < 4) w[i] = q[i];
            p ^= q[i];
          end
          m_pend_word = w;
          m_pend_perr = PAR ? p : 1'b0;
          m_pend = 1;
          q.delete();
        end
      end else begin
        q.delete();
      end
    end
  endtask

  typedef struct {
    logic       r, c, s, rd;
    logic [3:0] word;
    logic       valid, bsy, ovr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [7:0] bits;

`ifndef SHIFT_DESER_PARITY_EN
    // Basic word 1101, then abort after two bits and a clean 0100.
    tbl[0]  = '{1, 0, 0, 1, 4'h0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 4'h0, 0, 1, 0};
    tbl[2]  = '{0, 1, 0, 1, 4'h0, 0, 1, 0};
    tbl[3]  = '{0, 1, 1, 1, 4'h0, 0, 1, 0};
    tbl[4]  = '{0, 1, 1, 1, 4'h0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 4'hD, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 4'hD, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 1, 4'hD, 0, 1, 0};
    tbl[8]  = '{0, 1, 1, 1, 4'hD, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 4'hD, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 4'hD, 0, 1, 0};
    tbl[11] = '{0, 1, 0, 1, 4'hD, 0, 1, 0};
    tbl[12] = '{0, 1, 1, 1, 4'hD, 0, 1, 0};
    tbl[13] = '{0, 1, 0, 1, 4'hD, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 4'h4, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 4'h4, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].s, tbl[i].rd);
      chk($sformatf("tbl%0d_word", i), out_word, tbl[i].word);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].ovr);
    end

    // Overrun: 1111 then 0001 back-to-back with the consumer stalled.
    drive(1, 0, 0, 0);
    bits = 8'b0001_1111;
    for (int i = 0; i < 8; i++) drive(0, 1, bits[i], 0);
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_word", out_word, 4'hF);
    chk("ovr_not_yet", overrun, 0);
    drive(0, 0, 0, 0);
    chk("ovr_word_held", out_word, 4'hF);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid_held", out_valid, 1);
    drive(0, 0, 0, 1);
    chk("ovr_valid_drop", out_valid, 0);
    chk("ovr_sticky1", overrun, 1);
    drive(0, 0, 0, 1);
    chk("ovr_sticky2", overrun, 1);
    drive(1, 0, 0, 1);
    chk("ovr_rst_clear", overrun, 0);

    // Accept of 1010 on the same edge that 0110 loads.
    bits = 8'b0110_1010;
    for (int i = 0; i < 8; i++) drive(0, 1, bits[i], 0);
    chk("sim_held_word", out_word, 4'hA);
    chk("sim_held_valid", out_valid, 1);
    drive(0, 0, 0, 1);
    chk("sim_new_word", out_word, 4'h6);
    chk("sim_valid_stays", out_valid, 1);
    chk("sim_no_ovr", overrun, 0);
    drive(0, 0, 0, 1);
    chk("sim_valid_drop", out_valid, 0);

    // Reset mid-word, then a clean 0110.
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("rmw_busy", busy, 1);
    drive(1, 1, 1, 0);
    chk("rmw_word0", out_word, 0);
    chk("rmw_valid0", out_valid, 0);
    chk("rmw_busy0", busy, 0);
    chk("rmw_ovr0", overrun, 0);
    chk("rmw_perr0", parity_err, 0);
    bits = 8'b0000_0110;
    for (int i = 0; i < 4; i++) drive(0, 1, bits[i], 1);
    drive(0, 0, 0, 1);
    chk("rmw_word", out_word, 4'h6);
    chk("rmw_valid", out_valid, 1);
`else
    // Data 1,1,0,1 with good parity 1, then with bad parity 0.
    drive(1, 0, 0, 1);
    chk("par_rst_perr", parity_err, 0);
    bits = 8'b0001_1011;
    for (int i = 0; i < 5; i++) drive(0, 1, bits[i], 1);
    drive(0, 0, 0, 1);
    chk("par_ok_word", out_word, 4'hB);
    chk("par_ok_valid", out_valid, 1);
    chk("par_ok_perr", parity_err, 0);
    bits = 8'b0000_1011;
    for (int i = 0; i < 5; i++) drive(0, 1, bits[i], 1);
    drive(0, 0, 0, 1);
    chk("par_bad_word", out_word, 4'hB);
    chk("par_bad_perr", parity_err, 1);
`endif

    // Random traffic against the model.
    rst = 1; cntrl = 0; sin = 0; out_ready = 0;
    model_step();
    tick();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      cntrl     = ($urandom_range(0, 9) != 0);
      sin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      model_step();
      tick();
      chk("rnd_word", out_word, m_word);
      chk("rnd_valid", out_valid, m_valid);
      chk("rnd_busy", busy, (q.size() != 0));
      chk("rnd_ovr", overrun, m_ovr);
      chk("rnd_perr", parity_err, m_perr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-in, parallel-out receiver. It is the far end of the team's `shift` parallel-to-serial transmitter: it takes the LSB-first serial bit stream plus frame-enable `cntrl` and reassembles WIDTH-bit words.
- Completed words are presented on a valid/ready output port with a single holding register and a sticky overrun flag.
- It sits between a serial link and the parallel datapath consumer.

Parameters:
- WIDTH, 4, data word width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- cntrl  input  1  frame enable. High: sin is sampled every clk. Low: partial word is discarded and the bit counter is cleared.
- sin  input  1  serial data bit, LSB first.
- out_word  output  WIDTH  last completed word, registered.
- out_valid  output  1  out_word holds an unconsumed word.
- out_ready  input  1  consumer accepts out_word when out_valid && out_ready.
- busy  output  1  a partial word is in progress (bit counter != 0).
- overrun  output  1  sticky: a completed word was dropped.
- parity_err  output  1  parity result for out_word; tied 0 unless PARITY_EN is defined.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): out_word=0, out_valid=0, busy=0, overrun=0, parity_err=0, shift register=0, bit counter=0, state=IDLE. Reset mid-word discards the partial word.
- States:
  - IDLE (counter=0).
  - SHIFT (0<counter<FRAME).
  - FRAME = WIDTH, or WIDTH+1 with PARITY_EN.
- Transitions:
  - IDLE->SHIFT on the first clk with cntrl=1.
  - SHIFT stays in SHIFT while cntrl=1 and counter<FRAME-1.
  - On the last bit of a frame, the counter wraps to 0. Cntrl held high starts the next frame on the very next clk, with no gap cycle.
  - Any state->IDLE when cntrl=0. Counter is cleared and the partial word dropped. out_word, out_valid and overrun are unaffected.
- Sampling: each clk with cntrl=1, sr <= {sin, sr[WIDTH-1:1]} for data bits. The first received bit lands in bit 0 after WIDTH shifts.
- Counter width: $clog2(FRAME+1). It never exceeds FRAME-1.
- Completion (last frame bit sampled at edge N):
  - At edge N+1, out_word = assembled word and out_valid = 1. Latency is 1 clk after the last bit.
  - If out_valid=1 and out_ready=0 at completion: the new word is dropped, out_word is held, and overrun <= 1. overrun stays 1 until rst.
  - If out_valid=1 and out_ready=1 on the completion edge: the old word counts as accepted, the new word loads, out_valid stays 1, and there is no overrun.
  - If out_valid=0 at completion: the word loads and out_valid <= 1.
- Handshake: out_valid drops the clk after out_valid && out_ready, unless a new word completes on that same edge. out_word is stable while out_valid=1 and out_ready=0.
- busy = (counter != 0), registered.
- cntrl=0 and completion never coincide: the completing bit is only sampled when cntrl=1.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, so data bits plus parity bit have an even count of 1s.
  - The parity bit is not shifted into sr.
  - parity_err loads together with out_word: 1 if parity mismatched. The word is delivered regardless.
- Undefined: frame = WIDTH bits, parity_err is constant 0, and no parity logic is built.

Decomposition:
- Shared package shift_pkg:
  - default WIDTH constant;
  - state enum typedef {IDLE, SHIFT};
  - FRAME_LEN function(WIDTH, parity);
  - counter-width helper.
- The package is also reusable by the transmitter.
- No sub-module is warranted. The shift register, counter/FSM and output holding register stay in one module.

Test Plan (WIDTH=4):
- Basic word: rst, out_ready=1, cntrl=1, sin=1,0,1,1.
  - out_valid=1 one clk after the 4th bit, out_word=4'b1101.
  - out_valid=0 the following clk.
- Abort: cntrl=1 with sin=1,1, then cntrl=0 for one clk, then cntrl=1 with sin=0,0,1,0.
  - busy=0 during the abort clk.
  - Exactly one word, out_word=4'b0100.
- Overrun: out_ready=0, words 1111 then 0001 (sin=1,0,0,0) back-to-back.
  - out_word stays 4'b1111 and overrun=1 one clk after the 8th bit.
  - Raise out_ready: out_valid drops, overrun stays 1 until rst.
- Simultaneous accept and complete: out_valid=1 holding 1010, out_ready=1 on the completion edge of 0110.
  - out_word=4'b0110, out_valid stays 1, overrun=0.
- Reset mid-word: rst=1 after 2 bits.
  - All outputs 0 next clk.
  - The following 4 bits 0,1,1,0 give out_word=4'b0110 with no residue.
- Parity (SHIFT_DESER_PARITY_EN): bits 1,1,0,1 + parity 1.
  - out_word=4'b1011, parity_err=0.
  - Repeat with parity 0: parity_err=1.
